// File: rtl/hb2_pkg.sv
// Shared constants, coefficient table, state type and output rounding for the
// time-multiplexed 35-tap halfband decimator.
package hb2_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 36;
    localparam int NTAPS  = 35;
    localparam int NPAIRS = 9;
    localparam int CENTER = 17;
    localparam int PTR_W  = 6;

    localparam logic signed [COEF_W-1:0] HB2_COEF [0:NPAIRS-1] = '{
        16'sd1471, -16'sd548, 16'sd670, -16'sd834, 16'sd1062,
        -16'sd1416, 16'sd2030, -16'sd3443, 16'sd10418
    };
    localparam logic signed [COEF_W-1:0] CENTER_COEF = 16'sd16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAIR = 2'd1,
        CTR  = 2'd2,
        OUT  = 2'd3
    } hb2_state_t;

    // Round half up to Q15 and clamp into the signed output range.
    function automatic logic signed [DATA_W-1:0] hb2_round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] w_sh;
        w_sh = (acc + 36'sd16384) >>> 15;
        if (w_sh > 36'sd32767) begin
            return 16'sh7fff;
        end else if (w_sh < -36'sd32768) begin
            return 16'sh8000;
        end else begin
            return w_sh[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/hb2_sample_ram.sv
// 35-entry circular sample store: one write port, two combinational tap reads
// addressed by age (0 = newest) relative to the write pointer.
module hb2_sample_ram
    import hb2_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_we,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]         i_tap_a,
    input  logic [PTR_W-1:0]         i_tap_b,
    output logic signed [DATA_W-1:0] o_rdata_a,
    output logic signed [DATA_W-1:0] o_rdata_b
);

    logic signed [DATA_W-1:0] r_mem [0:NTAPS-1];
    logic [PTR_W-1:0]         r_wp;

    // (wp - 1 - k) mod 35 computed as wp + 34 - k, folded once; valid for wp, k in 0..34.
    function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] k);
        logic [PTR_W:0] w_sum;
        logic [PTR_W:0] w_fold;
        w_sum  = {1'b0, wp} + 7'd34 - {1'b0, k};
        w_fold = w_sum - 7'd35;
        if (w_sum >= 7'd35) begin
            return w_fold[PTR_W-1:0];
        end else begin
            return w_sum[PTR_W-1:0];
        end
    endfunction

    assign o_rdata_a = r_mem[tap_addr(r_wp, i_tap_a)];
    assign o_rdata_b = r_mem[tap_addr(r_wp, i_tap_b)];

    // Sample storage and write pointer; reset and clear both flush to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            for (int j = 0; j < NTAPS; j++) begin
                r_mem[j] <= '0;
            end
            r_wp <= 6'd0;
        end else if (i_we) begin
            r_mem[r_wp] <= i_wdata;
            r_wp        <= (r_wp == 6'd34) ? 6'd0 : r_wp + 6'd1;
        end
    end

endmodule

// File: rtl/hb2_mac_sched.sv
// Halfband decimate-by-2 filter on one pre-adder, one multiplier and one
// accumulator: 9 symmetric pair cycles, 1 centre cycle, 1 output cycle.
module hb2_mac_sched
    import hb2_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic signed [DATA_W-1:0] i_x_in,
    input  logic                     i_x_valid,
    output logic                     o_x_ready,
    output logic signed [DATA_W-1:0] o_y_out,
    output logic                     o_y_valid
);

    hb2_state_t               r_state;
    logic [3:0]               r_i;
    logic                     r_phase;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_x_ready;
    logic signed [DATA_W-1:0] r_y_out;
    logic                     r_y_valid;

    logic                     w_accept;
    logic [PTR_W-1:0]         w_tap_a;
    logic [PTR_W-1:0]         w_tap_b;
    logic signed [DATA_W-1:0] w_rd_a;
    logic signed [DATA_W-1:0] w_rd_b;
    logic signed [DATA_W:0]   w_opnd;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [COEF_W+DATA_W:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;

    assign w_accept  = i_x_valid & r_x_ready;
    assign o_x_ready = r_x_ready;
    assign o_y_out   = r_y_out;
    assign o_y_valid = r_y_valid;

    hb2_sample_ram u_ram (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_clear),
        .i_we      (w_accept),
        .i_wdata   (i_x_in),
        .i_tap_a   (w_tap_a),
        .i_tap_b   (w_tap_b),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Tap addressing: pair i reads taps 2i and 34-2i; the centre cycle reads tap 17 on port a.
    always_comb begin
        w_tap_a = {1'b0, r_i, 1'b0};
        w_tap_b = 6'd34 - {1'b0, r_i, 1'b0};
        if (r_state == CTR) begin
            w_tap_a = 6'(CENTER);
        end else begin
            w_tap_a = {1'b0, r_i, 1'b0};
        end
    end

    // Pre-add and coefficient select; the centre tap bypasses the pre-adder.
    always_comb begin
        w_opnd = {w_rd_a[DATA_W-1], w_rd_a};
        w_coef = CENTER_COEF;
        if (r_state == PAIR) begin
            w_opnd = {w_rd_a[DATA_W-1], w_rd_a} + {w_rd_b[DATA_W-1], w_rd_b};
            w_coef = HB2_COEF[r_i];
        end else begin
            w_opnd = {w_rd_a[DATA_W-1], w_rd_a};
            w_coef = CENTER_COEF;
        end
    end

    assign w_prod     = $signed({{(DATA_W+1){w_coef[COEF_W-1]}}, w_coef})
                      * $signed({{COEF_W{w_opnd[DATA_W]}}, w_opnd});
    assign w_prod_ext = {{(ACC_W-COEF_W-DATA_W-1){w_prod[COEF_W+DATA_W]}}, w_prod};

    // Scheduler FSM with MAC accumulator and registered handshake/output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_i       <= 4'd0;
            r_phase   <= 1'b0;
            r_acc     <= '0;
            r_x_ready <= 1'b1;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
        end else if (i_clear) begin
            r_state   <= IDLE;
            r_i       <= 4'd0;
            r_phase   <= 1'b0;
            r_acc     <= '0;
            r_x_ready <= 1'b1;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_phase <= ~r_phase;
                        if (r_phase) begin
                            r_state   <= PAIR;
                            r_acc     <= '0;
                            r_i       <= 4'd0;
                            r_x_ready <= 1'b0;
                        end
                    end
                end
                PAIR: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_i == 4'(NPAIRS-1)) begin
                        r_state <= CTR;
                    end else begin
                        r_i <= r_i + 4'd1;
                    end
                end
                CTR: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= OUT;
                end
                OUT: begin
                    r_y_out   <= hb2_round_sat(r_acc);
                    r_y_valid <= 1'b1;
                    r_x_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_x_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hb2_mac_sched.sv
// Scoreboard bench for hb2_mac_sched: a direct 35-tap convolution model queues
// the expected output at every second accepted sample.
module tb_hb2_mac_sched;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic signed [15:0] x_in;
    logic               x_valid;
    logic               x_ready;
    logic signed [15:0] y_out;
    logic               y_valid;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int yv_cnt = 0;

    int exp_q[$];
    int got_q[$];
    int ref_q[$];
    int acc_cyc_q[$];
    int yv_cyc_q[$];

    int hcoef[35];
    int m_buf[35];
    bit m_phase;

    int W_TBL[9]    = '{1471, -548, 670, -834, 1062, -1416, 2030, -3443, 10418};
    int IMP_ODD[18] = '{1471, -548, 670, -834, 1062, -1416, 2030, -3443, 10418,
                        10418, -3443, 2030, -1416, 1062, -834, 670, -548, 1471};

    hb2_mac_sched dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (clear),
        .i_x_in    (x_in),
        .i_x_valid (x_valid),
        .o_x_ready (x_ready),
        .o_y_out   (y_out),
        .o_y_valid (y_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 35; k++) m_buf[k] = 0;
        m_phase = 1'b0;
    endtask

    task automatic model_accept(input int x);
        longint acc;
        longint r;
        for (int k = 34; k > 0; k--) m_buf[k] = m_buf[k-1];
        m_buf[0] = x;
        if (m_phase) begin
            acc = 0;
            for (int k = 0; k < 35; k++) acc += longint'(hcoef[k]) * longint'(m_buf[k]);
            r = (acc + 64'sd16384) >>> 15;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            exp_q.push_back(int'(r));
        end
        m_phase = ~m_phase;
    endtask

    // Output monitor: every y_valid pulse is compared to the head of the scoreboard.
    always @(negedge clk) begin
        if (y_valid) begin
            yv_cnt++;
            yv_cyc_q.push_back(cyc);
            got_q.push_back(int'(y_out));
            if (exp_q.size() == 0) chk("y_unexpected", 1, 0);
            else chk("y_out", int'(y_out), exp_q.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int x);
        int n;
        x_in = 16'(x);
        x_valid = 1'b1;
        n = 0;
        while (!x_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            model_accept(x);
            @(negedge clk);
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        int n;
        x_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        x_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        exp_q.delete();
        got_q.delete();
    endtask

    // Abort a computation at pair index 4, by reset or by clear.
    task automatic abort_run(input bit use_reset, input int hold_y);
        int yv0;
        send(3000);
        send(-4000);
        x_valid = 1'b0;
        repeat (4) @(negedge clk);
        yv0 = yv_cnt;
        if (use_reset) reset = 1'b1;
        else clear = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear = 1'b0;
        model_reset();
        exp_q.delete();
        chk(use_reset ? "abort_rst_ready" : "abort_clr_ready", int'(x_ready), 1);
        chk(use_reset ? "abort_rst_yout" : "abort_clr_yout", int'(y_out), hold_y);
        repeat (15) @(negedge clk);
        chk(use_reset ? "abort_rst_noyv" : "abort_clr_noyv", yv_cnt, yv0);
        got_q.delete();
        send(0);
        send(0);
        drain();
        chk("after_abort_size", got_q.size(), 1);
        if (got_q.size() > 0) chk("after_abort_y", got_q[0], 0);
    endtask

    initial begin
        int v;
        for (int k = 0; k < 35; k++) hcoef[k] = 0;
        for (int i = 0; i < 9; i++) begin
            hcoef[2*i]    = W_TBL[i];
            hcoef[34-2*i] = W_TBL[i];
        end
        hcoef[17] = 16384;
        model_reset();
        reset = 1'b1;
        clear = 1'b0;
        x_in = 16'sd0;
        x_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", int'(x_ready), 1);
        chk("rst_yvalid", int'(y_valid), 0);
        chk("rst_yout", int'(y_out), 0);

        // Impulse on the odd sample exposes every coefficient in order.
        got_q.delete();
        send(0);
        send(32767);
        repeat (34) send(0);
        drain();
        chk("imp_odd_count", got_q.size(), 18);
        for (int m = 0; m < 18 && m < got_q.size(); m++) chk("imp_odd", got_q[m], IMP_ODD[m]);

        // Impulse on the even sample only meets the centre tap.
        do_clear();
        send(32767);
        repeat (35) send(0);
        drain();
        chk("imp_even_count", got_q.size(), 18);
        if (got_q.size() == 18) begin
            chk("imp_even_m0", got_q[0], 0);
            chk("imp_even_m8", got_q[8], 16384);
            chk("imp_even_m17", got_q[17], 0);
        end

        // DC gain and saturation in both directions.
        for (int t = 0; t < 3; t++) begin
            do_clear();
            v = (t == 0) ? 16384 : (t == 1) ? 32767 : -32768;
            repeat (40) send(v);
            drain();
            if (got_q.size() > 0)
                chk("dc_steady", got_q[got_q.size()-1], (t == 0) ? 17602 : (t == 1) ? 32767 : -32768);
            else
                chk("dc_no_output", 0, 1);
        end

        // Handshake timing with x_valid held high.
        do_clear();
        acc_cyc_q.delete();
        yv_cyc_q.delete();
        send(10);
        send(20);
        chk("hs_busy_ready", int'(x_ready), 0);
        send(30);
        send(40);
        drain();
        if (acc_cyc_q.size() == 4 && yv_cyc_q.size() >= 1) begin
            chk("hs_acc_gap01", acc_cyc_q[1] - acc_cyc_q[0], 1);
            chk("hs_acc_gap12", acc_cyc_q[2] - acc_cyc_q[1], 12);
            chk("hs_acc_gap23", acc_cyc_q[3] - acc_cyc_q[2], 1);
            chk("hs_yv_latency", yv_cyc_q[0] - acc_cyc_q[1], 11);
        end else begin
            chk("hs_event_count", acc_cyc_q.size(), 4);
        end

        // Same stream with and without random valid gaps must match.
        do_clear();
        for (int i = 0; i < 24; i++) send((i * 1237) % 20000 - 9000);
        drain();
        ref_q = got_q;
        do_clear();
        for (int i = 0; i < 24; i++) begin
            x_valid = 1'b0;
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send((i * 1237) % 20000 - 9000);
        end
        drain();
        chk("gap_count", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) chk("gap_seq", got_q[i], ref_q[i]);

        // Abort mid-computation: reset zeroes y_out, clear holds it.
        do_clear();
        abort_run(1'b1, 0);
        do_clear();
        send(5000);
        send(7000);
        drain();
        v = int'(y_out);
        chk("pre_clear_nonzero", int'(v != 0), 1);
        abort_run(1'b0, v);

        // Long ramp so the write pointer wraps several times.
        do_clear();
        for (int i = 0; i < 120; i++) send(i * 301 - 18000);
        drain();
        chk("wrap_count", got_q.size(), 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
